// File: rtl/uart_rx_deframer.sv
// Frame parser downstream of the UART RX FIFO. It hunts for SOF, reads LEN, streams the
// payload over valid/ready and checks an 8-bit additive checksum covering LEN and payload.
module uart_rx_deframer #(
  parameter int              DataLength    = 8,
  parameter int              MaxLength     = 64,
  parameter logic [DataLength-1:0] SofByte = 8'hA5,
  parameter int              TimeoutCycles = 4340
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_rdy,
  input  logic [DataLength-1:0] i_rx_data,
  output logic                  o_rx_req,
  output logic [DataLength-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_frame_ok,
  output logic                  o_frame_err,
  output logic [1:0]            o_err_code,
  output logic [7:0]            o_drop_cnt
);

  localparam int                  TmoW    = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0]     TmoLast = TmoW'(TimeoutCycles - 1);
  localparam logic [DataLength-1:0] MaxLen = DataLength'(MaxLength);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK} state_t;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CHK     = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  state_t                  state;
  logic [DataLength-1:0]   sum;
  logic [DataLength-1:0]   remaining;
  logic [TmoW-1:0]         idle_cnt;
  logic                    pop;
  logic                    expire;

  // NOTE: the pop is combinational so a byte is taken in the same cycle it is requested;
  // it only fires when the output register is free or being drained, so one byte is in flight.
  assign pop      = i_rx_rdy & (~o_valid | i_ready) & ~i_rst;
  assign o_rx_req = pop;

  // Only cycles with an empty FIFO count; a downstream stall with data waiting never times out.
  assign expire = (state != S_IDLE) && !i_rx_rdy && (idle_cnt == TmoLast);

  // NOTE: every register here is state, so all updates are non-blocking and share one reset branch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      sum         <= '0;
      remaining   <= '0;
      idle_cnt    <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_drop_cnt  <= '0;
    end else begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;

      if (o_valid && i_ready) o_valid <= 1'b0;

      if (pop || state == S_IDLE || expire) idle_cnt <= '0;
      else if (!i_rx_rdy)                   idle_cnt <= idle_cnt + 1'b1;

      if (expire) begin
        state       <= S_IDLE;
        o_frame_err <= 1'b1;
        o_err_code  <= ERR_TIMEOUT;
      end else if (pop) begin
        case (state)
          S_IDLE: begin
            if (i_rx_data == SofByte)      state      <= S_LEN;
            else if (o_drop_cnt != 8'hFF)  o_drop_cnt <= o_drop_cnt + 1'b1;
          end
          S_LEN: begin
            sum       <= i_rx_data;
            remaining <= i_rx_data;
            if (i_rx_data > MaxLen) begin
              state       <= S_IDLE;
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_LEN;
            end else if (i_rx_data == '0) begin
              state <= S_CHECK;
            end else begin
              state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            o_data    <= i_rx_data;
            o_valid   <= 1'b1;
            o_last    <= (remaining == DataLength'(1));
            sum       <= sum + i_rx_data;
            remaining <= remaining - 1'b1;
            if (remaining == DataLength'(1)) state <= S_CHECK;
          end
          S_CHECK: begin
            state <= S_IDLE;
            if (i_rx_data == sum) begin
              o_frame_ok <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_CHK;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: stimulus pushes expected beats and frame results,
// a negedge monitor pops and compares them whenever the DUT presents output.
module tb_uart_rx_deframer;

  localparam int         MaxLength     = 64;
  localparam int         TimeoutCycles = 4340;
  localparam logic [7:0] Sof           = 8'hA5;
  localparam int         ResOk         = 8;   // result code for a good frame; errors use 1..3

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx_rdy = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       o_rx_req;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic       i_ready = 1'b1;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [1:0] o_err_code;
  logic [7:0] o_drop_cnt;

  uart_rx_deframer #(
    .DataLength   (8),
    .MaxLength    (MaxLength),
    .SofByte      (Sof),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_rdy   (i_rx_rdy),
    .i_rx_data  (i_rx_data),
    .o_rx_req   (o_rx_req),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .i_ready    (i_ready),
    .o_frame_ok (o_frame_ok),
    .o_frame_err(o_frame_err),
    .o_err_code (o_err_code),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_beats[$];
  int    exp_results[$];
  int    n_checks   = 0;
  int    n_errors   = 0;
  int    drop_model = 0;
  int    gap_max    = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Random downstream readiness, changed just after each rising edge.
  always @(posedge i_clk) begin
    if (rand_ready) begin
      #1;
      i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every accepted payload beat and every frame pulse against the queues.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        if (exp_beats.size() == 0) begin
          fail_now($sformatf("beat_unexpected data=%0h last=%0b", o_data, o_last));
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          check("payload_beat", {o_data, o_last}, {e.data, e.last});
        end
      end
      if (o_frame_ok || o_frame_err) begin
        check("pulse_exclusive", 32'(o_frame_ok & o_frame_err), 32'd0);
        if (exp_results.size() == 0) begin
          fail_now($sformatf("result_unexpected ok=%0b err=%0b code=%0d",
                             o_frame_ok, o_frame_err, o_err_code));
        end else begin
          int r;
          r = exp_results.pop_front();
          check("frame_result", o_frame_ok ? ResOk : 32'(o_err_code), r);
        end
      end
    end
  end

  // Presents one byte at the FIFO head after 'gap' empty cycles and waits until it is popped.
  // Entered and left just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit done;
    int waited;
    done   = 1'b0;
    waited = 0;
    if (gap > 0) begin
      i_rx_rdy = 1'b0;
      repeat (gap) begin
        @(posedge i_clk);
        #1;
      end
    end
    i_rx_rdy  = 1'b1;
    i_rx_data = b;
    while (!done) begin
      @(negedge i_clk);
      if (o_rx_req) begin
        done = 1'b1;
      end else if (++waited > 1000) begin
        fail_now("pop_wait_expired");
        done = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    i_rx_rdy = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], $urandom_range(0, gap_max));
  endtask

  // Reference model: expectations derived from the frame as a whole.
  task automatic good_frame(input int len, input bit corrupt);
    logic [7:0] q[$];
    int s;
    q.push_back(Sof);
    q.push_back(8'(len));
    s = len;
    for (int i = 0; i < len; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 255));
      q.push_back(p);
      s += p;
      exp_beats.push_back('{data: p, last: (i == len - 1)});
    end
    if (corrupt) q.push_back(8'((s + $urandom_range(1, 255)) % 256));
    else         q.push_back(8'(s % 256));
    exp_results.push_back(corrupt ? 1 : ResOk);
    send_list(q);
  endtask

  task automatic len_err_frame(input int len);
    logic [7:0] q[$];
    q.push_back(Sof);
    q.push_back(8'(len));
    exp_results.push_back(2);
    send_list(q);
  endtask

  task automatic garbage(input int n);
    logic [7:0] q[$];
    for (int i = 0; i < n; i++) begin
      logic [7:0] g;
      do g = 8'($urandom_range(0, 255)); while (g == Sof);
      q.push_back(g);
    end
    drop_model = (drop_model + n > 255) ? 255 : drop_model + n;
    send_list(q);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && (exp_beats.size() != 0 || exp_results.size() != 0); i++)
      @(posedge i_clk);
    #1;
    check("drain_beats", exp_beats.size(), 0);
    check("drain_results", exp_results.size(), 0);
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    @(negedge i_clk);
    check("req_low_in_reset", 32'(o_rx_req), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("reset_outputs", {o_valid, o_last, o_data, o_frame_ok, o_frame_err, o_err_code, o_drop_cnt}, 32'd0);
    @(posedge i_clk);
    #1;
    exp_beats.delete();
    exp_results.delete();
    drop_model = 0;
    i_rx_rdy   = 1'b0;
    i_rst      = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_state", {o_valid, o_last, o_data, o_frame_ok, o_frame_err, o_err_code, o_drop_cnt}, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Good frame, back to back.
    exp_beats.push_back('{8'h11, 1'b0});
    exp_beats.push_back('{8'h22, 1'b0});
    exp_beats.push_back('{8'h33, 1'b1});
    exp_results.push_back(ResOk);
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h69, 0);
    @(negedge i_clk);
    check("good_ok_timing", {o_frame_ok, o_frame_err}, 2'b10);
    @(posedge i_clk); #1;

    // Bad checksum, then an empty good frame.
    exp_beats.push_back('{8'h10, 1'b0});
    exp_beats.push_back('{8'h20, 1'b1});
    exp_results.push_back(1);
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    @(negedge i_clk);
    check("chk_err_timing", {o_frame_ok, o_frame_err, o_err_code}, {1'b0, 1'b1, 2'd1});
    @(posedge i_clk); #1;
    exp_results.push_back(ResOk);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);

    // Length error, the trailing byte is discarded in the hunt.
    exp_results.push_back(2);
    send_byte(8'hA5, 0); send_byte(8'h41, 0);
    @(negedge i_clk);
    check("len_err_timing", {o_frame_err, o_err_code}, {1'b1, 2'd2});
    @(posedge i_clk); #1;
    send_byte(8'h05, 0);
    drop_model++;
    check("drop_after_len_err", o_drop_cnt, drop_model);

    // Timeout exactly TimeoutCycles after the last pop.
    exp_beats.push_back('{8'h10, 1'b0});
    exp_results.push_back(3);
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    repeat (TimeoutCycles - 1) @(posedge i_clk);
    @(negedge i_clk);
    check("timeout_not_early", 32'(o_frame_err), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("timeout_fire", {o_frame_err, o_err_code}, {1'b1, 2'd3});
    @(posedge i_clk); #1;

    // A byte arriving on the last counted cycle keeps the frame alive.
    exp_beats.push_back('{8'h10, 1'b0});
    exp_beats.push_back('{8'h20, 1'b1});
    exp_results.push_back(ResOk);
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    send_byte(8'h20, TimeoutCycles - 1);
    send_byte(8'h32, 0);
    drain();

    // Garbage before a frame, counted from a fresh reset.
    apply_reset();
    exp_results.push_back(ResOk);
    send_byte(8'h00, 0); send_byte(8'hFF, 0);
    drop_model += 2;
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("drop_cnt_garbage", o_drop_cnt, 32'd2);
    drain();

    // Randomized frames with gaps and downstream backpressure.
    rand_ready = 1'b1;
    gap_max    = 2;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 3))
        0: good_frame($urandom_range(0, MaxLength), 1'b0);
        1: good_frame($urandom_range(1, MaxLength), 1'b1);
        2: begin
          len_err_frame($urandom_range(MaxLength + 1, 255));
          garbage($urandom_range(0, 3));
        end
        default: garbage($urandom_range(1, 4));
      endcase
      check("drop_cnt_random", o_drop_cnt, drop_model);
    end
    good_frame(MaxLength, 1'b0);
    rand_ready = 1'b0;
    gap_max    = 0;
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    drain();

    // Drop counter saturation.
    garbage(260);
    check("drop_cnt_saturate", o_drop_cnt, 32'd255);

    // Downstream stall mid-payload: no pop, output held, no timeout.
    i_ready = 1'b0;
    exp_beats.push_back('{8'h11, 1'b0});
    exp_beats.push_back('{8'h22, 1'b0});
    exp_beats.push_back('{8'h33, 1'b0});
    exp_beats.push_back('{8'h44, 1'b1});
    exp_results.push_back(ResOk);
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h11, 0);
    i_rx_rdy  = 1'b1;
    i_rx_data = 8'h22;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      check("stall_no_req", 32'(o_rx_req), 32'd0);
      check("stall_hold", {o_valid, o_data, o_frame_err}, {1'b1, 8'h11, 1'b0});
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0); send_byte(8'hAE, 0);
    drain();

    // Reset in the middle of a frame with a byte pending downstream.
    i_ready = 1'b0;
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h55, 0);
    i_rx_rdy  = 1'b1;
    i_rx_data = 8'h66;
    apply_reset();
    i_ready = 1'b1;
    good_frame(3, 1'b0);
    drain();
    check("drop_cnt_final", o_drop_cnt, drop_model);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
